pixel_writer: RTL and testbench

- Sits directly downstream of the raytracing controller and consumes its per-pixel output stream (valid, x, y, 16-bit value).
- Buffers pixels in a small FIFO and computes the linear framebuffer address.
- Writes pixels into the back half of a double-buffered framebuffer BRAM through a valid/ready port.
- Swaps front and back buffers on the first vsync after a frame is fully written.

---
 rtl/proctypes.sv | 26 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/pixel_writer.sv | 131 +++++++++++++
 tb/tb_pixel_writer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proctypes.sv
// Shared processor/raster types: screen coordinates, framebuffer addressing
// and the pixel writer's state encoding.
package proctypes;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 180;
    localparam int FB_AW         = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);

    typedef logic [$clog2(SCREEN_WIDTH)-1:0]  ScreenX;
    typedef logic [$clog2(SCREEN_HEIGHT)-1:0] ScreenY;

    // Top bit selects the buffer half, the rest is y*width+x.
    typedef logic [FB_AW:0] FbAddr;

    typedef struct packed {
        FbAddr       addr;
        logic [15:0] value;
    } PixelWrite;

    typedef enum logic [1:0] {
        PW_IDLE,
        PW_DRAW,
        PW_WAIT_SWAP
    } pw_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; pushes when full and pops when
// empty are ignored, and flush empties it in one cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define validity,
    // and leaving it unreset lets it map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pixel_writer.sv
// Buffers raytracer pixels, writes them into the back half of a double-buffered
// framebuffer and swaps halves on the first vsync after a complete frame.
module pixel_writer
    import proctypes::*;
#(
    parameter int SCREEN_W   = SCREEN_WIDTH,
    parameter int SCREEN_H   = SCREEN_HEIGHT,
    parameter int FIFO_DEPTH = 8,
    parameter int PIX_AW     = $clog2(SCREEN_W * SCREEN_H)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            pixel_valid,
    input  ScreenX          pixel_x,
    input  ScreenY          pixel_y,
    input  logic [15:0]     pixel_value,
    output logic            fb_we,
    output logic [PIX_AW:0] fb_addr,
    output logic [15:0]     fb_data,
    input  logic            fb_ready,
    input  logic            vsync,
    output logic            front_buf,
    output logic            busy,
    output logic            frame_done,
    output logic            err_drop
);

    typedef struct packed {
        logic [PIX_AW:0] addr;
        logic [15:0]     value;
    } pix_t;

    localparam logic [PIX_AW:0] FRAME_PIXELS = (PIX_AW+1)'(SCREEN_W * SCREEN_H);
    localparam logic [PIX_AW:0] COUNT_ONE    = (PIX_AW+1)'(1);

    pw_state_e       state;
    logic            back_buf;
    logic [PIX_AW:0] count;

    logic            in_range;
    logic            accept;
    logic            push;
    logic            drop;
    logic            load;
    logic            xfer;
    logic            fifo_full;
    logic            fifo_empty;
    logic [PIX_AW-1:0] lin_addr;
    pix_t            push_pix;
    pix_t            head;

    assign in_range = (int'(pixel_x) < SCREEN_W) && (int'(pixel_y) < SCREEN_H);
    assign lin_addr = PIX_AW'(int'(pixel_y) * SCREEN_W + int'(pixel_x));
    assign push_pix = '{addr: {back_buf, lin_addr}, value: pixel_value};

    // Fullness is the registered flag, so a full FIFO drops even if it pops this cycle.
    assign accept = (state == PW_DRAW) && in_range && !fifo_full;
    assign push   = pixel_valid && !frame_start && accept;
    assign drop   = pixel_valid && !frame_start && !accept;

    assign xfer = fb_we && fb_ready;
    assign load = !fifo_empty && (!fb_we || fb_ready);
    assign busy = (state != PW_IDLE);

    sync_fifo #(
        .WIDTH($bits(pix_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (frame_start),
        .push     (push),
        .push_data(push_pix),
        .pop      (load && !frame_start),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PW_IDLE;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            front_buf  <= 1'b0;
            back_buf   <= 1'b1;
            frame_done <= 1'b0;
            err_drop   <= 1'b0;
            count      <= '0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start) begin
                // Restart the frame into the same back buffer; any pending swap is forgotten.
                state    <= PW_DRAW;
                fb_we    <= 1'b0;
                count    <= '0;
                err_drop <= 1'b0;
            end else begin
                if (drop) err_drop <= 1'b1;

                if (load) begin
                    fb_we   <= 1'b1;
                    fb_addr <= head.addr;
                    fb_data <= head.value;
                end else if (xfer) begin
                    fb_we <= 1'b0;
                end

                if (xfer) count <= count + COUNT_ONE;

                case (state)
                    PW_DRAW: begin
                        if (xfer && (count + COUNT_ONE == FRAME_PIXELS)) state <= PW_WAIT_SWAP;
                    end
                    PW_WAIT_SWAP: begin
                        if (vsync) begin
                            front_buf  <= back_buf;
                            back_buf   <= ~back_buf;
                            frame_done <= 1'b1;
                            state      <= PW_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer on a 4x2 screen with a 4-entry FIFO.
module tb_pixel_writer;
    import proctypes::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        pixel_valid = 1'b0;
    ScreenX      pixel_x = '0;
    ScreenY      pixel_y = '0;
    logic [15:0] pixel_value = '0;
    logic        fb_we;
    logic [3:0]  fb_addr;
    logic [15:0] fb_data;
    logic        fb_ready = 1'b1;
    logic        vsync = 1'b0;
    logic        front_buf;
    logic        busy;
    logic        frame_done;
    logic        err_drop;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int w0;

    logic [19:0] sb[$];
    logic        stalled = 1'b0;
    logic [19:0] held;

    pixel_writer #(
        .SCREEN_W  (4),
        .SCREEN_H  (2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .pixel_valid(pixel_valid),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pixel_value(pixel_value),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_ready   (fb_ready),
        .vsync      (vsync),
        .front_buf  (front_buf),
        .busy       (busy),
        .frame_done (frame_done),
        .err_drop   (err_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input logic [15:0] v, input bit acc, input bit back);
        logic [2:0] lin;
        lin         = 3'(y * 4 + x);
        pixel_valid = 1'b1;
        pixel_x     = ScreenX'(x);
        pixel_y     = ScreenY'(y);
        pixel_value = v;
        if (acc) sb.push_back({back, lin, v});
        tick();
        pixel_valid = 1'b0;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0 && !fb_we) break;
            tick();
        end
        check("drain", 32'((sb.size() != 0) || fb_we), 0);
    endtask

    // Scoreboard side: every accepted write is compared with the oldest expected pixel,
    // and a stalled write must hold its address and data.
    always @(negedge clk) begin
        if (rst || frame_start) begin
            stalled = 1'b0;
        end else begin
            if (stalled && fb_we) check("stall_stable", {12'd0, fb_addr, fb_data}, {12'd0, held});
            stalled = fb_we && !fb_ready;
            held    = {fb_addr, fb_data};
            if (fb_we && fb_ready) begin
                logic [19:0] e;
                writes++;
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 32'(fb_addr), 32'(e[19:16]));
                    check("wr_data", 32'(fb_data), 32'(e[15:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_fb_we", 32'(fb_we), 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_data", 32'(fb_data), 0);
        check("rst_front", 32'(front_buf), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_err", 32'(err_drop), 0);

        // Single pixel latency
        pulse_frame_start();
        check("fs_busy", 32'(busy), 1);
        send(1, 1, 16'hF800, 1, 1);
        check("lat_we_early", 32'(fb_we), 0);
        tick();
        check("lat_we", 32'(fb_we), 1);
        check("lat_addr", 32'(fb_addr), 32'h0D);
        check("lat_data", 32'(fb_data), 32'hF800);
        check("lat_busy", 32'(busy), 1);
        check("lat_front", 32'(front_buf), 0);
        drain();

        // Full frame back to back, then swap
        pulse_frame_start();
        w0 = writes;
        for (int i = 0; i < 8; i++) send(i % 4, i / 4, 16'h1000 + 16'(i), 1, 1);
        drain();
        check("frame1_writes", 32'(writes - w0), 8);
        check("wait_busy", 32'(busy), 1);
        check("wait_front", 32'(front_buf), 0);
        pulse_vsync();
        check("swap_done", 32'(frame_done), 1);
        check("swap_front", 32'(front_buf), 1);
        check("swap_busy", 32'(busy), 0);
        tick();
        check("done_pulse", 32'(frame_done), 0);

        // Pixel while idle is dropped
        send(0, 0, 16'hAAAA, 0, 0);
        check("idle_err", 32'(err_drop), 1);
        tick();
        tick();
        check("idle_no_we", 32'(fb_we), 0);
        pulse_frame_start();
        check("fs_err_clear", 32'(err_drop), 0);
        send(2, 0, 16'h0BEE, 1, 0);
        drain();

        // Out-of-range column
        send(4, 0, 16'h5555, 0, 0);
        tick();
        tick();
        check("oor_err", 32'(err_drop), 1);
        check("oor_no_we", 32'(fb_we), 0);
        pulse_frame_start();
        check("fs_err_clear2", 32'(err_drop), 0);

        // Backpressure: 1 in output register + 4 in FIFO, 6th dropped
        fb_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(i % 4, i / 4, 16'h2000 + 16'(i), i < 5, 0);
        check("stall_err", 32'(err_drop), 1);
        check("stall_we", 32'(fb_we), 1);
        tick();
        tick();
        tick();
        w0 = writes;
        fb_ready = 1'b1;
        drain();
        check("stall_writes", 32'(writes - w0), 5);

        // Final transfer coincides with vsync: no swap until the next vsync
        pulse_frame_start();
        for (int i = 0; i < 8; i++) send(i % 4, i / 4, 16'h3000 + 16'(i), 1, 0);
        tick();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("same_edge_busy", 32'(busy), 1);
        check("same_edge_front", 32'(front_buf), 1);
        check("same_edge_done", 32'(frame_done), 0);
        check("same_edge_we", 32'(fb_we), 0);
        tick();
        check("same_edge_done2", 32'(frame_done), 0);

        // Restart from WAIT_SWAP cancels the swap and redraws the same buffer
        pulse_frame_start();
        check("restart_busy", 32'(busy), 1);
        check("restart_front", 32'(front_buf), 1);
        pulse_vsync();
        check("draw_vsync_front", 32'(front_buf), 1);
        check("draw_vsync_done", 32'(frame_done), 0);
        w0 = writes;
        for (int i = 0; i < 8; i++) send(i % 4, i / 4, 16'h4000 + 16'(i), 1, 0);
        drain();
        check("redraw_writes", 32'(writes - w0), 8);
        check("redraw_busy", 32'(busy), 1);
        pulse_vsync();
        check("swap2_done", 32'(frame_done), 1);
        check("swap2_front", 32'(front_buf), 0);
        check("swap2_busy", 32'(busy), 0);

        // Reset in the middle of a stalled stream
        pulse_frame_start();
        fb_ready = 1'b0;
        send(0, 0, 16'h6000, 1, 1);
        send(1, 0, 16'h6001, 1, 1);
        check("pre_rst_we", 32'(fb_we), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("mid_rst_we", 32'(fb_we), 0);
        check("mid_rst_front", 32'(front_buf), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_addr", 32'(fb_addr), 0);
        fb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_empty", 32'(fb_we), 0);
        end
        check("sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
